// File: rtl/uart_tx_param.sv
// -----------------------------------------------------------------------------
// uart_tx_param
//   Parametrised UART transmitter. Accepts one word per frame over a
//   valid/ready handshake and serialises it as START, DATA, optional PARITY
//   and STOP bits on a registered serial line O, which idles high.
//
// Parameters
//   DATA_WIDTH    payload bits per frame (5..9)
//   CLKS_PER_BIT  clock cycles each serial bit is held (>=1)
//   PARITY_MODE   0 = none, 1 = even, 2 = odd
//   STOP_BITS     1 or 2
//   LSB_FIRST     1 = data[0] first, 0 = data[DATA_WIDTH-1] first
//
// Ports
//   CLK    in   clock, all state on rising edge
//   RESET  in   synchronous reset, active-high
//   valid  in   producer has a word on data
//   data   in   word to transmit, sampled only on accept
//   ready  out  block can accept a word (high only in IDLE)
//   busy   out  frame in progress (= ~ready)
//   O      out  serial line, registered
// -----------------------------------------------------------------------------
module uart_tx_param #(
  parameter int DATA_WIDTH   = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY_MODE  = 0,
  parameter int STOP_BITS    = 1,
  parameter int LSB_FIRST    = 1
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  valid,
  input  logic [DATA_WIDTH-1:0] data,
  output logic                  ready,
  output logic                  busy,
  output logic                  O
);

  localparam int BIT_W  = $clog2(DATA_WIDTH + 1);
  localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BAUD_W-1:0] BAUD_ONE  = BAUD_W'(1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_WIDTH - 1);
  localparam logic [BIT_W-1:0]  STOP_LAST = BIT_W'(STOP_BITS - 1);
  localparam logic [BIT_W-1:0]  BIT_ONE   = BIT_W'(1);
  localparam bit                HAS_PARITY = (PARITY_MODE != 0);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;

  logic [2:0]            state_q,  state_d;
  logic [DATA_WIDTH-1:0] shift_q,  shift_d;
  logic                  parity_q, parity_d;
  logic [BAUD_W-1:0]     baud_q,   baud_d;
  logic [BIT_W-1:0]      bit_q,    bit_d;
  logic                  o_q,      o_d;

  logic                  baud_last;
  logic [DATA_WIDTH-1:0] shift_next;

  // The bit on the wire is always taken from the "head" end of the shift
  // register; which end that is depends on the configured bit order.
  function automatic logic head_bit(input logic [DATA_WIDTH-1:0] v);
    return (LSB_FIRST != 0) ? v[0] : v[DATA_WIDTH-1];
  endfunction

  assign baud_last  = (baud_q == BAUD_LAST);
  assign shift_next = (LSB_FIRST != 0) ? (shift_q >> 1) : (shift_q << 1);

  // NOTE: every signal written here gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    state_d  = state_q;
    shift_d  = shift_q;
    parity_d = parity_q;
    baud_d   = baud_q;
    bit_d    = bit_q;
    o_d      = o_q;

    // Baud counter free-runs 0..CLKS_PER_BIT-1 whenever a frame is active.
    if (state_q != S_IDLE) begin
      baud_d = baud_last ? '0 : (baud_q + BAUD_ONE);
    end

    // o_d is the value O must show in the cycle after this edge, so each
    // transition loads the first value of the state being entered.
    case (state_q)
      S_IDLE: begin
        o_d    = 1'b1;
        baud_d = '0;
        bit_d  = '0;
        if (valid) begin
          shift_d  = data;
          parity_d = (PARITY_MODE == 2) ? ~(^data) : (^data);
          state_d  = S_START;
          o_d      = 1'b0;
        end
      end

      S_START: begin
        if (baud_last) begin
          bit_d   = '0;
          state_d = S_DATA;
          o_d     = head_bit(shift_q);
        end
      end

      S_DATA: begin
        if (baud_last) begin
          if (bit_q == BIT_LAST) begin
            bit_d = '0;
            if (HAS_PARITY) begin
              state_d = S_PARITY;
              o_d     = parity_q;
            end else begin
              state_d = S_STOP;
              o_d     = 1'b1;
            end
          end else begin
            bit_d   = bit_q + BIT_ONE;
            shift_d = shift_next;
            o_d     = head_bit(shift_next);
          end
        end
      end

      S_PARITY: begin
        if (baud_last) begin
          bit_d   = '0;
          state_d = S_STOP;
          o_d     = 1'b1;
        end
      end

      S_STOP: begin
        o_d = 1'b1;
        if (baud_last) begin
          // bit_q counts stop periods here.
          if (bit_q == STOP_LAST) begin
            bit_d   = '0;
            state_d = S_IDLE;
          end else begin
            bit_d = bit_q + BIT_ONE;
          end
        end
      end

      default: begin
        state_d = S_IDLE;
        o_d     = 1'b1;
        baud_d  = '0;
        bit_d   = '0;
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values computed above.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q  <= S_IDLE;
      shift_q  <= '0;
      parity_q <= 1'b0;
      baud_q   <= '0;
      bit_q    <= '0;
      o_q      <= 1'b1;
    end else begin
      state_q  <= state_d;
      shift_q  <= shift_d;
      parity_q <= parity_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      o_q      <= o_d;
    end
  end

  // Decoded from registered state only: no combinational valid->ready path.
  assign ready = (state_q == S_IDLE);
  assign busy  = ~ready;
  assign O     = o_q;

endmodule

// File: tb/tb_uart_tx_param.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_param
//   Drives six differently configured uart_tx_param instances from a shared
//   clock and reset. A frame-level model (list of frame bits, cycle index)
//   predicts O/ready/busy for every instance every cycle; directed tests add
//   hand-computed literal frames, frame lengths and accept spacing.
//
//   Instances: 0: 8N1 cpb4   1: 8E1 cpb4   2: 8O1 cpb4
//              3: 8N1 cpb2 MSB first   4: 7O2 cpb3   5: 8N1 cpb1
// -----------------------------------------------------------------------------
module tb_uart_tx_param;

  localparam int N = 6;

  logic       CLK = 1'b0;
  logic       RESET;
  logic [N-1:0] valid_v;
  logic [8:0] data_v [N];
  logic [N-1:0] o_v, ready_v, busy_v;

  int dw  [N] = '{8, 8, 8, 8, 7, 8};
  int cpb [N] = '{4, 4, 4, 2, 3, 1};
  int par [N] = '{0, 1, 2, 0, 2, 0};
  int stp [N] = '{1, 1, 1, 1, 2, 1};
  int lsb [N] = '{1, 1, 1, 0, 1, 1};

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  bit armed  = 1'b0;

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  uart_tx_param #(.DATA_WIDTH(8), .CLKS_PER_BIT(4), .PARITY_MODE(0), .STOP_BITS(1), .LSB_FIRST(1)) u_a (
    .CLK(CLK), .RESET(RESET), .valid(valid_v[0]), .data(data_v[0][7:0]),
    .ready(ready_v[0]), .busy(busy_v[0]), .O(o_v[0]));
  uart_tx_param #(.DATA_WIDTH(8), .CLKS_PER_BIT(4), .PARITY_MODE(1), .STOP_BITS(1), .LSB_FIRST(1)) u_b (
    .CLK(CLK), .RESET(RESET), .valid(valid_v[1]), .data(data_v[1][7:0]),
    .ready(ready_v[1]), .busy(busy_v[1]), .O(o_v[1]));
  uart_tx_param #(.DATA_WIDTH(8), .CLKS_PER_BIT(4), .PARITY_MODE(2), .STOP_BITS(1), .LSB_FIRST(1)) u_c (
    .CLK(CLK), .RESET(RESET), .valid(valid_v[2]), .data(data_v[2][7:0]),
    .ready(ready_v[2]), .busy(busy_v[2]), .O(o_v[2]));
  uart_tx_param #(.DATA_WIDTH(8), .CLKS_PER_BIT(2), .PARITY_MODE(0), .STOP_BITS(1), .LSB_FIRST(0)) u_d (
    .CLK(CLK), .RESET(RESET), .valid(valid_v[3]), .data(data_v[3][7:0]),
    .ready(ready_v[3]), .busy(busy_v[3]), .O(o_v[3]));
  uart_tx_param #(.DATA_WIDTH(7), .CLKS_PER_BIT(3), .PARITY_MODE(2), .STOP_BITS(2), .LSB_FIRST(1)) u_e (
    .CLK(CLK), .RESET(RESET), .valid(valid_v[4]), .data(data_v[4][6:0]),
    .ready(ready_v[4]), .busy(busy_v[4]), .O(o_v[4]));
  uart_tx_param #(.DATA_WIDTH(8), .CLKS_PER_BIT(1), .PARITY_MODE(0), .STOP_BITS(1), .LSB_FIRST(1)) u_f (
    .CLK(CLK), .RESET(RESET), .valid(valid_v[5]), .data(data_v[5][7:0]),
    .ready(ready_v[5]), .busy(busy_v[5]), .O(o_v[5]));

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- frame-level model ----------------
  // While busy, m_t counts cycles since the accept edge (0..F-1); the line
  // shows frame bit m_t / CLKS_PER_BIT.
  logic        m_busy [N];
  int          m_t    [N];
  int          m_len  [N];
  logic [15:0] m_bits [N];

  always @(posedge CLK) begin
    for (int i = 0; i < N; i++) begin
      logic [15:0] fb;
      int          nb;
      logic        x;
      if (RESET) begin
        m_busy[i] <= 1'b0;
        m_t[i]    <= 0;
      end else if (!m_busy[i]) begin
        if (valid_v[i]) begin
          fb = '0;
          nb = 1;                       // frame bit 0 is the start bit (0)
          x  = 1'b0;
          for (int k = 0; k < dw[i]; k++) begin
            fb[nb] = data_v[i][(lsb[i] != 0) ? k : (dw[i] - 1 - k)];
            x      = x ^ data_v[i][k];
            nb++;
          end
          if (par[i] != 0) begin
            fb[nb] = (par[i] == 1) ? x : ~x;
            nb++;
          end
          for (int s = 0; s < stp[i]; s++) begin
            fb[nb] = 1'b1;
            nb++;
          end
          m_bits[i] <= fb;
          m_len[i]  <= nb * cpb[i];
          m_t[i]    <= 0;
          m_busy[i] <= 1'b1;
        end
      end else begin
        m_t[i] <= m_t[i] + 1;
        if (m_t[i] + 1 == m_len[i]) m_busy[i] <= 1'b0;
      end
    end
  end

  always @(negedge CLK) begin
    if (armed) begin
      for (int i = 0; i < N; i++) begin
        logic exp_o;
        exp_o = m_busy[i] ? m_bits[i][m_t[i] / cpb[i]] : 1'b1;
        check($sformatf("model_o dut%0d cyc%0d", i, cyc), int'(o_v[i]), int'(exp_o));
        check($sformatf("model_ready dut%0d cyc%0d", i, cyc), int'(ready_v[i]), int'(!m_busy[i]));
        check($sformatf("model_busy dut%0d cyc%0d", i, cyc), int'(busy_v[i]), int'(m_busy[i]));
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  // Called at a negedge. Presents a word, waits (bounded) for ready, lets the
  // accept edge pass and returns 1 time unit after it.
  task automatic send(input int i, input logic [8:0] d, input bit hold, output int acc_cyc);
    int budget;
    data_v[i]  = d;
    valid_v[i] = 1'b1;
    budget = 0;
    while (!ready_v[i] && budget < 200) begin
      @(negedge CLK);
      budget++;
    end
    if (!ready_v[i]) check($sformatf("accept_timeout dut%0d", i), 0, 1);
    @(posedge CLK);
    #1;
    acc_cyc = cyc;
    if (!hold) valid_v[i] = 1'b0;
  endtask

  // Called right after send. Samples the first cycle of each bit period,
  // first bit ending up as the MSB of the result, then checks the frame ends
  // exactly after nb*CLKS_PER_BIT cycles.
  task automatic check_frame(input int i, input int nb, input int exp, input string name);
    int bits = 0;
    for (int k = 0; k < nb * cpb[i]; k++) begin
      @(negedge CLK);
      if (k % cpb[i] == 0) bits = (bits << 1) | int'(o_v[i]);
    end
    check({name, "_bits"}, bits, exp);
    check({name, "_ready_last_cycle"}, int'(ready_v[i]), 0);
    @(negedge CLK);
    check({name, "_ready_after"}, int'(ready_v[i]), 1);
    check({name, "_o_after"}, int'(o_v[i]), 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int c1, c2, ca, cb;
    RESET   = 1'b1;
    valid_v = '0;
    for (int i = 0; i < N; i++) data_v[i] = '0;
    @(negedge CLK);
    @(negedge CLK);
    RESET = 1'b0;
    armed = 1'b1;

    // 1: idle after reset
    for (int k = 0; k < 20; k++) begin
      @(negedge CLK);
      check("t1_idle_o", int'(o_v[0]), 1);
      check("t1_idle_ready", int'(ready_v[0]), 1);
      check("t1_idle_busy", int'(busy_v[0]), 0);
    end

    // 2: 8N1 cpb4 0xA5
    send(0, 9'h0A5, 1'b0, c1);
    check_frame(0, 10, 'b0101001011, "t2_8n1");

    // 3: even / odd parity on 0xA5, 44-cycle frames
    @(negedge CLK);
    fork
      send(1, 9'h0A5, 1'b0, ca);
      send(2, 9'h0A5, 1'b0, cb);
    join
    fork
      check_frame(1, 11, 'b01010010101, "t3_even");
      check_frame(2, 11, 'b01010010111, "t3_odd");
    join

    // 4: MSB first 0x0F; 7O2 0x55
    @(negedge CLK);
    fork
      send(3, 9'h00F, 1'b0, ca);
      send(4, 9'h055, 1'b0, cb);
    join
    fork
      check_frame(3, 10, 'b0000011111, "t4_msb_first");
      check_frame(4, 11, 'b01010101111, "t4_7o2");
    join

    // 5: valid held high across two words -> accepts F+1 = 41 cycles apart
    @(negedge CLK);
    send(0, 9'h011, 1'b1, c1);
    data_v[0] = 9'h022;
    @(negedge CLK);
    send(0, 9'h022, 1'b0, c2);
    check("t5_accept_spacing", c2 - c1, 41);
    // a one-cycle valid pulse while busy must be dropped
    repeat (10) @(negedge CLK);
    check("t5_busy_at_pulse", int'(busy_v[0]), 1);
    data_v[0]  = 9'h077;
    valid_v[0] = 1'b1;
    @(negedge CLK);
    valid_v[0] = 1'b0;
    repeat (45) @(negedge CLK);
    check("t5_dropped_ready", int'(ready_v[0]), 1);
    check("t5_dropped_o", int'(o_v[0]), 1);

    // 6: reset in the 3rd data bit (cycles 13..16 after accept), then a clean frame
    send(0, 9'h05A, 1'b0, c1);
    repeat (13) @(negedge CLK);
    check("t6_in_data_bit2", int'(o_v[0]), 0);
    RESET = 1'b1;
    @(negedge CLK);
    RESET = 1'b0;
    check("t6_reset_o", int'(o_v[0]), 1);
    check("t6_reset_ready", int'(ready_v[0]), 1);
    check("t6_reset_busy", int'(busy_v[0]), 0);
    send(0, 9'h03C, 1'b0, c1);
    check_frame(0, 10, 'b0001111001, "t6_after_reset");

    // CLKS_PER_BIT = 1 boundary
    @(negedge CLK);
    send(5, 9'h0C3, 1'b0, c1);
    check_frame(5, 10, 'b0110000111, "t7_cpb1");

    repeat (5) @(negedge CLK);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
